// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multi-cycle MIPS datapath
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       alu_zero_i,
  input  logic       alu_neg_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       alusrc_a_o,
  output logic [1:0] alusrc_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic [1:0] regdst_o,
  output logic [1:0] memtoreg_o,
  output logic       trap_o,
  output logic [1:0] trap_code_o,
  output logic       retire_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BLTZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLE   = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic          wb_rd_q, wb_rd_d;       // WB_ALU writes rd (R-type) instead of rt
  logic          trap_q;
  logic [1:0]    trap_code_q, trap_code_d;
  logic          mem_phase;
  logic          timeout;
  logic          taken;

  // States that hold a request to the shared memory
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Last permitted wait cycle passes without an ack; an ack in that cycle still wins
  assign timeout   = mem_phase && !mem_ack_i && (wait_q == CW'(MEM_TIMEOUT - 1));

  assign trap_o      = trap_q;
  assign trap_code_o = trap_code_q;

  // Branch condition from the A-B flags of the current instruction
  always_comb begin
    taken = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken = alu_zero_i;
      OP_BNE:  taken = !alu_zero_i;
      OP_BLE:  taken = alu_zero_i | alu_neg_i;
      OP_BLTZ: taken = alu_neg_i;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d     = state_q;
    wb_rd_d     = wb_rd_q;
    trap_code_d = trap_code_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    reg_write_o = 1'b0;
    alusrc_a_o  = 1'b0;
    alusrc_b_o  = 2'b00;
    alu_op_o    = 3'b000;
    pc_source_o = 2'b00;
    regdst_o    = 2'b00;
    memtoreg_o  = 2'b00;
    retire_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        alusrc_b_o = 2'b01;
        if (mem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d     = S_TRAP;
          trap_code_d = 2'b10;
        end
      end
      S_DECODE: begin
        alusrc_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:                      state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI:              state_d = S_EXEC_I;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ: state_d = S_BRANCH;
          OP_J, OP_JAL:                  state_d = S_JUMP;
          default: begin
            state_d     = S_TRAP;
            trap_code_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        alusrc_a_o = 1'b1;
        alu_op_o   = 3'b010;
        if (funct_i == FN_JR) begin
          pc_source_o = 2'b11;
          pc_write_o  = 1'b1;
          retire_o    = 1'b1;
          state_d     = S_FETCH;
        end else begin
          wb_rd_d = 1'b1;
          state_d = S_WB_ALU;
        end
      end
      S_EXEC_I: begin
        alusrc_a_o = 1'b1;
        alusrc_b_o = 2'b10;
        alu_op_o   = (opcode_i == OP_SLTI) ? 3'b011 : 3'b000;
        wb_rd_d    = 1'b0;
        state_d    = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write_o = 1'b1;
        regdst_o    = wb_rd_q ? 2'b01 : 2'b00;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alusrc_a_o = 1'b1;
        alusrc_b_o = 2'b10;
        state_d    = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ack_i) begin
          state_d = S_WB_MEM;
        end else if (timeout) begin
          state_d     = S_TRAP;
          trap_code_d = 2'b10;
        end
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ack_i) begin
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout) begin
          state_d     = S_TRAP;
          trap_code_d = 2'b10;
        end
      end
      S_WB_MEM: begin
        reg_write_o = 1'b1;
        memtoreg_o  = 2'b01;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a_o  = 1'b1;
        alu_op_o    = 3'b001;
        pc_source_o = 2'b01;
        pc_write_o  = taken;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        if (opcode_i == OP_JAL) begin
          reg_write_o = 1'b1;
          regdst_o    = 2'b10;
          memtoreg_o  = 2'b10;
        end
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State, wait counter and sticky trap registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      wb_rd_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_code_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      wb_rd_q     <= wb_rd_d;
      trap_code_q <= trap_code_d;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      // Any state change restarts the count, so every memory state starts from zero
      if (state_d != state_q) wait_q <= '0;
      else if (mem_phase && !mem_ack_i) wait_q <= wait_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic       clk_i;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       alu_zero_i;
  logic       alu_neg_i;
  logic       mem_ack_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       reg_write_o;
  logic       alusrc_a_o;
  logic [1:0] alusrc_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] pc_source_o;
  logic [1:0] regdst_o;
  logic [1:0] memtoreg_o;
  logic       trap_o;
  logic [1:0] trap_code_o;
  logic       retire_o;

  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          cycles;
    int          fetch_req;
    int          data_req;
    int          we_cyc;
    int          pcw;
    logic [16:0] last;
  } exp_t;

  exp_t sb[$];

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .alusrc_a_o(alusrc_a_o), .alusrc_b_o(alusrc_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .regdst_o(regdst_o), .memtoreg_o(memtoreg_o),
    .trap_o(trap_o), .trap_code_o(trap_code_o), .retire_o(retire_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are then sampled
  task automatic drive(input logic rst, input logic ack);
    @(negedge clk_i);
    rst_i     = rst;
    mem_ack_i = ack;
    #2;
  endtask

  // Instruction-level reference: cycle totals and the retiring cycle's controls
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic n, input int wf, input int wd);
    exp_t e;
    logic pw, rw, mq, mw, io, aa, tk;
    logic [1:0] ps, rd, mr, ab;
    logic [2:0] ao;
    pw = 0; rw = 0; mq = 0; mw = 0; io = 0; aa = 0;
    ps = 0; rd = 0; mr = 0; ab = 0; ao = 0;
    e.fetch_req = wf + 1;
    e.data_req  = 0;
    e.we_cyc    = 0;
    e.cycles    = wf + 3;
    case (op)
      6'd0: begin
        if (fn == 6'd8) begin
          pw = 1; ps = 2'b11; aa = 1; ao = 3'b010;
        end else begin
          e.cycles = wf + 4; rw = 1; rd = 2'b01;
        end
      end
      6'd8, 6'd10: begin
        e.cycles = wf + 4; rw = 1;
      end
      6'd35: begin
        e.cycles = wf + wd + 5; e.data_req = wd + 1; rw = 1; mr = 2'b01;
      end
      6'd43: begin
        e.cycles = wf + wd + 4; e.data_req = wd + 1; e.we_cyc = wd + 1;
        mq = 1; mw = 1; io = 1;
      end
      6'd2: begin
        pw = 1; ps = 2'b10;
      end
      6'd3: begin
        pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mr = 2'b10;
      end
      default: begin
        if (op == 6'd4)      tk = z;
        else if (op == 6'd5) tk = !z;
        else if (op == 6'd6) tk = z | n;
        else                 tk = n;
        pw = tk; ps = 2'b01; aa = 1; ao = 3'b001;
      end
    endcase
    e.pcw  = 1 + int'(pw);
    e.last = {pw, ps, rw, rd, mr, mq, mw, io, aa, ab, ao};
    return e;
  endfunction

  task automatic run_random(input int count);
    logic [5:0] ops [0:12];
    ops = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd10, 6'd35, 6'd43};
    for (int i = 0; i < count; i++) begin
      logic [5:0] op, fn;
      logic z, nn, mem;
      int wf, wd;
      exp_t e;
      op  = ops[$urandom_range(0, 12)];
      fn  = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
      z   = 1'($urandom);
      nn  = 1'($urandom);
      wf  = $urandom_range(0, TO - 1);
      wd  = $urandom_range(0, TO - 1);
      mem = (op == 6'd35) || (op == 6'd43);
      e   = model(op, fn, z, nn, wf, wd);
      sb.push_back(e);
      for (int c = 1; c <= e.cycles; c++) begin
        @(negedge clk_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;
        if (c == 1) begin
          opcode_i = op; funct_i = fn; alu_zero_i = z; alu_neg_i = nn;
        end
        if (c <= wf + 1)                            mem_ack_i = (c == wf + 1);
        else if (mem && c >= wf + 4 && c <= wf + 4 + wd) mem_ack_i = (c == wf + 4 + wd);
        else                                         mem_ack_i = 1'($urandom);
      end
    end
  endtask

  // Monitor: accumulate per-instruction activity, compare against the scoreboard on retire
  initial begin
    int cyc, fr, dr, wc, pwc, irc;
    exp_t e;
    cyc = 0; fr = 0; dr = 0; wc = 0; pwc = 0; irc = 0;
    forever begin
      @(negedge clk_i);
      #3;
      if (!mon_en) begin
        cyc = 0; fr = 0; dr = 0; wc = 0; pwc = 0; irc = 0;
      end else begin
        cyc++;
        if (mem_req_o && !iord_o)   fr++;
        if (mem_req_o && iord_o)    dr++;
        if (mem_req_o && mem_we_o)  wc++;
        if (pc_write_o)             pwc++;
        if (ir_write_o)             irc++;
        if (retire_o) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire actual=retire required=none");
          end else begin
            e = sb.pop_front();
            check("instr_cycles", cyc, e.cycles);
            check("fetch_req_cycles", fr, e.fetch_req);
            check("data_req_cycles", dr, e.data_req);
            check("write_req_cycles", wc, e.we_cyc);
            check("pc_write_count", pwc, e.pcw);
            check("ir_write_count", irc, 1);
            check("retire_controls",
                  {pc_write_o, pc_source_o, reg_write_o, regdst_o, memtoreg_o, mem_req_o,
                   mem_we_o, iord_o, alusrc_a_o, alusrc_b_o, alu_op_o}, e.last);
            check("no_trap_in_run", trap_o, 0);
          end
          cyc = 0; fr = 0; dr = 0; wc = 0; pwc = 0; irc = 0;
        end
      end
    end
  end

  // Directed boundary cases, then randomized instruction stream
  initial begin
    int   n;
    logic seen;
    rst_i = 1'b0; mem_ack_i = 1'b0; opcode_i = 6'd0; funct_i = 6'd32;
    alu_zero_i = 1'b0; alu_neg_i = 1'b0;

    drive(0, 0);
    drive(1, 0);
    check("rst_mem_req", mem_req_o, 1);
    check("rst_iord", iord_o, 0);
    check("rst_alusrc", {alusrc_a_o, alusrc_b_o, alu_op_o, pc_source_o}, 8'b0_01_000_00);
    check("rst_enables", {ir_write_o, pc_write_o, reg_write_o, retire_o}, 0);
    check("rst_trap", {trap_o, trap_code_o}, 0);

    n = mem_req_o ? 1 : 0;
    for (int k = 0; k < 12 && !trap_o; k++) begin
      drive(1, 0);
      if (mem_req_o) n++;
    end
    check("timeout_wait_cycles", n, TO);
    check("timeout_trap", {trap_o, trap_code_o}, 3'b110);

    seen = 1'b0;
    repeat (20) begin
      drive(1, 1'($urandom));
      seen |= mem_req_o | mem_we_o | ir_write_o | pc_write_o | reg_write_o | retire_o;
    end
    check("trap_timeout_quiet", seen, 0);
    check("trap_code_sticky", trap_code_o, 2'b10);

    drive(0, 1);
    drive(1, 0);
    check("reset_from_trap", {mem_req_o, trap_o, trap_code_o}, 4'b1000);
    drive(1, 0);
    drive(1, 0);
    drive(1, 1);
    check("late_ack_fetch", {ir_write_o, pc_write_o}, 2'b11);
    drive(1, 0);
    check("late_ack_no_trap", trap_o, 0);
    check("late_ack_decode", {mem_req_o, alusrc_b_o}, 3'b011);

    drive(0, 0);
    opcode_i = 6'h3F;
    drive(1, 1);
    drive(1, 0);
    drive(1, 0);
    check("illegal_trap", {trap_o, trap_code_o}, 3'b101);
    seen = 1'b0;
    repeat (20) begin
      drive(1, 1'($urandom));
      seen |= mem_req_o | mem_we_o | ir_write_o | pc_write_o | reg_write_o | retire_o;
    end
    check("trap_illegal_quiet", seen, 0);
    drive(0, 0);
    drive(1, 0);
    check("reset_after_illegal", {mem_req_o, trap_o, trap_code_o}, 4'b1000);

    drive(1, 0);
    drive(0, 1);
    drive(1, 0);
    n = mem_req_o ? 1 : 0;
    check("reset_mid_request", {mem_req_o, iord_o, ir_write_o}, 3'b100);
    for (int k = 0; k < 12 && !trap_o; k++) begin
      drive(1, 0);
      if (mem_req_o) n++;
    end
    check("counter_cleared_by_reset", n, TO);

    drive(0, 0);
    run_random(200);
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #4;
    end
    mon_en = 1'b0;
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
